// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and saturating stall/flush counters.
module pipe_stage_skid_reg #(
   parameter int unsigned              DATA_W    = 64,
   parameter logic [DATA_W-1:0]        RESET_VAL = '0,
   parameter int unsigned              CNT_W     = 16,
   parameter bit                       SKID_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
   logic                in_xfer, out_xfer, stall;

   assign out_valid = (state_q != StEmpty);
   assign out_data  = main_q;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   assign stall     = out_valid & ~out_ready;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   always_comb begin
      unique case (state_q)
         StOne:   occupancy = 2'd1;
         StFull:  occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Flush wins over everything; a concurrent input payload is dropped.
         state_d = StEmpty;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  state_d = StOne;
                  main_d  = in_data;
               end
            end
            StOne: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_data;
               end else if (in_xfer && SKID_EN) begin
                  state_d = StFull;
                  skid_d  = in_data;
               end else if (out_xfer) begin
                  state_d = StEmpty;
                  main_d  = RESET_VAL;
               end
            end
            StFull: begin
               if (out_xfer) begin
                  state_d = StOne;
                  main_d  = skid_q;
                  skid_d  = RESET_VAL;
               end
            end
            default: begin
               state_d = StEmpty;
               main_d  = RESET_VAL;
               skid_d  = RESET_VAL;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StEmpty;
         main_q      <= RESET_VAL;
         skid_q      <= RESET_VAL;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   if (SKID_EN) begin : g_skid
      // Registered ready: no combinational path from out_ready to in_ready.
      logic in_ready_q;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            in_ready_q <= 1'b1;
         end else begin
            in_ready_q <= (state_d != StFull);
         end
      end
      assign in_ready = in_ready_q;
   end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed self-checking bench: a skid instance (CNT_W=4) and a no-skid instance share clock/reset.
module tb_pipe_stage_skid_reg;

   localparam int unsigned      DW = 16;
   localparam int unsigned      CW = 4;
   localparam logic [DW-1:0]    RV = 16'hDEAD;

   logic          clk;
   logic          reset;
   logic          flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt, flush_cnt;

   logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [1:0]    b_occupancy;
   logic [CW-1:0] b_stall_cnt, b_flush_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   pipe_stage_skid_reg #(
      .DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW), .SKID_EN(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_skid_reg #(
      .DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW), .SKID_EN(1'b0)
   ) dut_b (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occupancy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

      // T1 reset with in_valid asserted
      step(); step();
      check("t1_out_valid", 32'(out_valid), 0);
      check("t1_out_data", 32'(out_data), 32'hDEAD);
      check("t1_in_ready", 32'(in_ready), 1);
      check("t1_occ", 32'(occupancy), 0);
      check("t1_stall", 32'(stall_cnt), 0);
      check("t1_flush", 32'(flush_cnt), 0);
      check("t1_b_in_ready", 32'(b_in_ready), 1);
      in_valid = 1'b0;
      #2 reset = 1'b1;

      // T2 streaming
      step();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0011;
      step();
      check("t2_d11", 32'(out_data), 32'h11);
      check("t2_occ1", 32'(occupancy), 1);
      in_data = 16'h0022;
      step();
      check("t2_d22", 32'(out_data), 32'h22);
      check("t2_occ2", 32'(occupancy), 1);
      in_data = 16'h0033;
      step();
      check("t2_d33", 32'(out_data), 32'h33);
      check("t2_v33", 32'(out_valid), 1);
      in_valid = 1'b0;
      step();
      check("t2_drain_valid", 32'(out_valid), 0);
      check("t2_drain_data", 32'(out_data), 32'hDEAD);
      check("t2_stall", 32'(stall_cnt), 0);

      // T3 skid
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
      step();
      in_data = 16'h000B;
      step();
      check("t3_occ2", 32'(occupancy), 2);
      check("t3_in_ready0", 32'(in_ready), 0);
      check("t3_hold_a", 32'(out_data), 32'hA);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check("t3_data_b", 32'(out_data), 32'hB);
      check("t3_occ1", 32'(occupancy), 1);
      check("t3_in_ready1", 32'(in_ready), 1);
      check("t3_stall", 32'(stall_cnt), 1);
      step();
      check("t3_empty", 32'(out_valid), 0);

      // T4 flush from FULL with a pending input
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
      step();
      in_data = 16'h000B;
      step();
      check("t4_full", 32'(occupancy), 2);
      in_data = 16'h000C; flush = 1'b1;
      #1 check("t4_in_ready_flush", 32'(in_ready), 0);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("t4_valid0", 32'(out_valid), 0);
      check("t4_data_rv", 32'(out_data), 32'hDEAD);
      check("t4_occ0", 32'(occupancy), 0);
      check("t4_flush_cnt", 32'(flush_cnt), 1);
      check("t4_in_ready1", 32'(in_ready), 1);
      step();
      check("t4_no_c", 32'(out_valid), 0);
      // Flush discards an accepted input from EMPTY
      in_valid = 1'b1; in_data = 16'h000C; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("t4_drop_occ", 32'(occupancy), 0);
      check("t4_flush_cnt2", 32'(flush_cnt), 2);
      check("t4_stall3", 32'(stall_cnt), 3);

      // T5 stall counter saturation, payload held bit-exact
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("t5_sat", 32'(stall_cnt), 15);
      check("t5_hold", 32'(out_data), 32'hBEEF);
      step();
      check("t5_sat_hold", 32'(stall_cnt), 15);
      out_ready = 1'b1;
      step();
      check("t5_drain", 32'(out_valid), 0);

      // T6 no-skid instance: combinational in_ready, no bubble
      b_in_valid = 1'b1; b_in_data = 16'h0061; b_out_ready = 1'b0;
      #1 check("t6_ready_empty", 32'(b_in_ready), 1);
      step();
      b_in_data = 16'h0062;
      #1 check("t6_ready0", 32'(b_in_ready), 0);
      step();
      check("t6_hold61", 32'(b_out_data), 32'h61);
      check("t6_occ1", 32'(b_occupancy), 1);
      b_out_ready = 1'b1;
      #1 check("t6_ready1", 32'(b_in_ready), 1);
      step();
      check("t6_d62", 32'(b_out_data), 32'h62);
      check("t6_v62", 32'(b_out_valid), 1);
      b_in_data = 16'h0063;
      step();
      check("t6_d63", 32'(b_out_data), 32'h63);
      check("t6_occ_not2", 32'(b_occupancy), 1);
      b_in_valid = 1'b0;
      step();
      check("t6_empty", 32'(b_occupancy), 0);

      // Asynchronous reset mid-operation
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0077;
      step();
      in_valid = 1'b0;
      step();
      check("rst_pre_valid", 32'(out_valid), 1);
      #2 reset = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 32'hDEAD);
      check("rst_stall", 32'(stall_cnt), 0);
      check("rst_flush", 32'(flush_cnt), 0);
      check("rst_b_stall", 32'(b_stall_cnt), 0);
      check("rst_in_ready", 32'(in_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
